// File: rtl/password_lock_ctrl_pkg.sv
// Shared types and default constants for the password attempt/lock controller.
package password_lock_ctrl_pkg;

  typedef enum logic [1:0] {
    ENTRY    = 2'd0,
    CHECK    = 2'd1,
    UNLOCKED = 2'd2,
    LOCKOUT  = 2'd3
  } lock_state_t;

  localparam int DEF_BITS_PER_TRY   = 4;
  localparam int DEF_MAX_FAILS      = 3;
  localparam int DEF_UNLOCK_CYCLES  = 8;
  localparam int DEF_LOCKOUT_CYCLES = 16;

  // Width holding max(a,b)-1, never narrower than one bit.
  function automatic int tmr_width(input int a, input int b);
    int m;
    m = (a > b) ? a : b;
    return ($clog2(m) < 1) ? 1 : $clog2(m);
  endfunction

endpackage

// File: rtl/password_lock_ctrl_timer.sv
// Loadable down-counter with zero flag, shared by the unlock and lockout windows.
module lock_timer
  import password_lock_ctrl_pkg::*;
#(
  parameter int W = tmr_width(DEF_UNLOCK_CYCLES, DEF_LOCKOUT_CYCLES)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic         zero
);

  logic [W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (dec) begin
      cnt <= cnt - W'(1);
    end
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/password_lock_ctrl.sv
// Frames serial key bits into fixed-length attempts, judges each attempt once,
// and runs a timed unlock window or a timed lockout after too many failures.
//
//   state    | meaning
//   ---------+-----------------------------------------------------------
//   ENTRY    | counting key bits of the current attempt
//   CHECK    | one cycle: detector match flag sampled, attempt judged
//   UNLOCKED | unlock window running on the shared timer
//   LOCKOUT  | lockout window running, key bits ignored
module password_lock_ctrl
  import password_lock_ctrl_pkg::*;
#(
  parameter int BITS_PER_TRY   = DEF_BITS_PER_TRY,
  parameter int MAX_FAILS      = DEF_MAX_FAILS,
  parameter int UNLOCK_CYCLES  = DEF_UNLOCK_CYCLES,
  parameter int LOCKOUT_CYCLES = DEF_LOCKOUT_CYCLES
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           bit_valid,
  input  logic                           match,
  output logic                           unlocked,
  output logic                           locked_out,
  output logic                           attempt_done,
  output logic                           attempt_ok,
  output logic [$clog2(MAX_FAILS+1)-1:0] fail_cnt
);

  localparam int FW = $clog2(MAX_FAILS + 1);
  localparam int BW = (BITS_PER_TRY > 1) ? $clog2(BITS_PER_TRY) : 1;
  localparam int TW = tmr_width(UNLOCK_CYCLES, LOCKOUT_CYCLES);

  lock_state_t   state;
  logic [BW-1:0] bit_cnt;
  logic          tmr_load;
  logic          tmr_dec;
  logic          tmr_zero;
  logic [TW-1:0] tmr_val;

  // The timer is loaded on the judging cycle with whichever window follows.
  assign tmr_load = (state == CHECK);
  assign tmr_val  = match ? TW'(UNLOCK_CYCLES - 1) : TW'(LOCKOUT_CYCLES - 1);
  assign tmr_dec  = ((state == UNLOCKED) || (state == LOCKOUT)) && !tmr_zero;

  lock_timer #(.W(TW)) u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (tmr_load),
    .load_val (tmr_val),
    .dec      (tmr_dec),
    .zero     (tmr_zero)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= ENTRY;
      bit_cnt      <= '0;
      fail_cnt     <= '0;
      attempt_done <= 1'b0;
      attempt_ok   <= 1'b0;
      unlocked     <= 1'b0;
      locked_out   <= 1'b0;
    end else begin
      attempt_done <= 1'b0;
      attempt_ok   <= 1'b0;
      // Window flags follow the state one cycle later, so each stays high for
      // exactly the number of cycles the state spends in its window.
      unlocked     <= (state == UNLOCKED);
      locked_out   <= (state == LOCKOUT);

      case (state)
        ENTRY: begin
          if (bit_valid) begin
            if (bit_cnt == BW'(BITS_PER_TRY - 1)) begin
              bit_cnt <= '0;
              state   <= CHECK;
            end else begin
              bit_cnt <= bit_cnt + BW'(1);
            end
          end
        end

        CHECK: begin
          attempt_done <= 1'b1;
          attempt_ok   <= match;
          if (match) begin
            fail_cnt <= '0;
            state    <= UNLOCKED;
          end else if (int'(fail_cnt) + 1 < MAX_FAILS) begin
            fail_cnt <= fail_cnt + FW'(1);
            state    <= ENTRY;
          end else begin
            fail_cnt <= FW'(MAX_FAILS);
            state    <= LOCKOUT;
          end
        end

        UNLOCKED: begin
          if (tmr_zero) state <= ENTRY;
        end

        LOCKOUT: begin
          if (tmr_zero) begin
            fail_cnt <= '0;
            state    <= ENTRY;
          end
        end

        default: state <= ENTRY;
      endcase
    end
  end

endmodule

// File: tb/tb_password_lock_ctrl.sv
// Randomized and directed stimulus for password_lock_ctrl, checked every cycle
// against a timeline model of attempts, windows and the failure count.
module tb_password_lock_ctrl;
  import password_lock_ctrl_pkg::*;

  localparam int B  = 4;
  localparam int MF = 3;
  localparam int U  = 8;
  localparam int L  = 16;
  localparam int FW = $clog2(MF + 1);

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          bit_valid = 1'b0;
  logic          match = 1'b0;
  logic          unlocked;
  logic          locked_out;
  logic          attempt_done;
  logic          attempt_ok;
  logic [FW-1:0] fail_cnt;

  always #5 clk = ~clk;

  password_lock_ctrl #(
    .BITS_PER_TRY   (B),
    .MAX_FAILS      (MF),
    .UNLOCK_CYCLES  (U),
    .LOCKOUT_CYCLES (L)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .bit_valid    (bit_valid),
    .match        (match),
    .unlocked     (unlocked),
    .locked_out   (locked_out),
    .attempt_done (attempt_done),
    .attempt_ok   (attempt_ok),
    .fail_cnt     (fail_cnt)
  );

  int n_chk  = 0;
  int n_fail = 0;
  int e      = 0;   // index of the next rising edge

  // Reference timeline: edge numbers at which events happen.
  int m_nbits       = 0;
  int m_fails       = 0;
  int m_check_at    = -1;
  int m_accept_from = 0;
  int m_unl_lo      = -1;
  int m_unl_hi      = -2;
  int m_lck_lo      = -1;
  int m_lck_hi      = -2;
  int m_done_at     = -1;
  int m_fclr_at     = -1;
  bit m_ok          = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s at edge %0d: got %0d, expected %0d", tag, e, obs, exp);
    end
  endtask

  task automatic model_edge(input logic bv, input logic m, input logic r);
    if (!r) begin
      m_nbits       = 0;
      m_fails       = 0;
      m_check_at    = -1;
      m_accept_from = e + 1;
      m_unl_lo      = -1;
      m_unl_hi      = -2;
      m_lck_lo      = -1;
      m_lck_hi      = -2;
      m_done_at     = -1;
      m_fclr_at     = -1;
    end else begin
      if (e == m_fclr_at) m_fails = 0;
      if (e == m_check_at) begin
        m_check_at = -1;
        m_done_at  = e;
        m_ok       = m;
        if (m) begin
          m_fails       = 0;
          m_unl_lo      = e + 1;
          m_unl_hi      = e + U;
          m_accept_from = e + U + 1;
        end else if (m_fails + 1 < MF) begin
          m_fails       = m_fails + 1;
          m_accept_from = e + 1;
        end else begin
          m_fails       = MF;
          m_lck_lo      = e + 1;
          m_lck_hi      = e + L;
          m_fclr_at     = e + L;
          m_accept_from = e + L + 1;
        end
      end else if (e >= m_accept_from && bv) begin
        m_nbits = m_nbits + 1;
        if (m_nbits == B) begin
          m_nbits    = 0;
          m_check_at = e + 1;
        end
      end
    end
  endtask

  task automatic tick(input logic bv, input logic m, input logic r);
    bit exp_done;
    bit_valid = bv;
    match     = m;
    rst_n     = r;
    @(posedge clk);
    model_edge(bv, m, r);
    @(negedge clk);
    exp_done = (m_done_at == e);
    chk("attempt_done", 32'(attempt_done), 32'(exp_done));
    chk("attempt_ok",   32'(attempt_ok),   32'(exp_done && m_ok));
    chk("unlocked",     32'(unlocked),     32'(e >= m_unl_lo && e <= m_unl_hi));
    chk("locked_out",   32'(locked_out),   32'(e >= m_lck_lo && e <= m_lck_hi));
    chk("fail_cnt",     32'(fail_cnt),     32'(m_fails));
    e++;
  endtask

  task automatic idle(input int n, input logic bv);
    for (int i = 0; i < n; i++) tick(bv, 1'b0, 1'b1);
  endtask

  task automatic send_try(input logic ok);
    for (int i = 0; i < B; i++) tick(1'b1, 1'b0, 1'b1);
    tick(1'b0, ok, 1'b1);
  endtask

  initial begin
    // reset state
    tick(1'b0, 1'b0, 1'b0);
    tick(1'b0, 1'b0, 1'b0);
    chk("rst_state", 32'(dut.state), 32'(ENTRY));
    idle(2, 1'b0);

    // correct attempt and full unlock window
    send_try(1'b1);
    idle(U + 2, 1'b0);

    // three wrong attempts, bits held high throughout the lockout
    send_try(1'b0);
    send_try(1'b0);
    send_try(1'b0);
    idle(L, 1'b1);
    chk("fail_after_lockout", 32'(fail_cnt), 32'd0);
    send_try(1'b1);
    idle(U + 1, 1'b0);

    // recovery after two failures
    send_try(1'b0);
    send_try(1'b0);
    send_try(1'b1);
    chk("recovered_fail_cnt", 32'(fail_cnt), 32'd0);
    idle(U + 1, 1'b0);

    // match pulse mid-attempt is ignored
    tick(1'b1, 1'b0, 1'b1);
    tick(1'b1, 1'b0, 1'b1);
    tick(1'b0, 1'b1, 1'b1);
    tick(1'b1, 1'b0, 1'b1);
    tick(1'b1, 1'b0, 1'b1);
    tick(1'b0, 1'b0, 1'b1);
    chk("mid_match_fail_cnt", 32'(fail_cnt), 32'd1);
    idle(2, 1'b0);

    // reset in the unlock window and mid-attempt
    send_try(1'b1);
    idle(2, 1'b0);
    tick(1'b0, 1'b0, 1'b0);
    chk("unlock_reset_drop", 32'(unlocked), 32'd0);
    tick(1'b1, 1'b0, 1'b1);
    tick(1'b1, 1'b0, 1'b1);
    tick(1'b0, 1'b0, 1'b0);
    send_try(1'b1);
    idle(U + 1, 1'b0);

    // randomized stream with occasional resets
    for (int i = 0; i < 3000; i++) begin
      logic r, bv, m;
      r  = ($urandom_range(0, 199) != 0);
      bv = ($urandom_range(0, 2) != 0);
      if (m_check_at == e) m = ($urandom_range(0, 2) == 0);
      else                 m = ($urandom_range(0, 3) == 0);
      tick(bv, m, r);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
